// File: rtl/lcd_pixel_feeder_pkg.sv
// ============================================================================
//  Module   : lcd_pixel_feeder_pkg
//  Brief    : Shared LCD geometry, RGB565 field positions, FSM encoding and
//             the RGB565-to-RGB888 expansion used by the pixel feeder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_pixel_feeder_pkg;

    localparam int LCD_H_ACT = 640;
    localparam int LCD_V_ACT = 480;

    localparam int R5_HI = 15;
    localparam int R5_LO = 11;
    localparam int G6_HI = 10;
    localparam int G6_LO = 5;
    localparam int B5_HI = 4;
    localparam int B5_LO = 0;

    localparam logic [1:0] ST_FLUSH   = 2'd0;
    localparam logic [1:0] ST_PREFILL = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the MSBs into the new LSBs maps full-scale to 0xFF exactly.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] pix);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        rgb888_t    o;
        r5  = pix[R5_HI:R5_LO];
        g6  = pix[G6_HI:G6_LO];
        b5  = pix[B5_HI:B5_LO];
        o.r = {r5, r5[4:2]};
        o.g = {g6, g6[5:4]};
        o.b = {b5, b5[4:2]};
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_pix_fifo.sv
// ============================================================================
//  Module   : lcd_pix_fifo
//  Brief    : Synchronous prefetch FIFO with occupancy count, synchronous
//             flush and empty-bypass for simultaneous push/pop.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_pix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             bypass;
    logic             do_wr;
    logic             do_rd;

    // On an empty FIFO a same-cycle push/pop passes the word straight through.
    assign bypass   = push && pop && (count == '0);
    assign do_wr    = push && !bypass;
    assign do_rd    = pop && !bypass;
    assign pop_data = (count == '0) ? push_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == (AW+1)'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/lcd_pixel_feeder.sv
// ============================================================================
//  Module   : lcd_pixel_feeder
//  Brief    : Prefetches RGB565 framebuffer words into a FIFO and answers the
//             LCD timing generator's data_req with registered RGB888 pixels.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_pixel_feeder
    import lcd_pixel_feeder_pkg::*;
#(
    parameter int          H_ACT      = LCD_H_ACT,
    parameter int          V_ACT      = LCD_V_ACT,
    parameter int          ADDR_W     = 19,
    parameter int          FIFO_DEPTH = 16,
    parameter int          AF_LEVEL   = 12,
    parameter int          RD_LAT     = 1,
    parameter logic [23:0] UF_COLOR   = 24'h000000
) (
    input  logic              lcd_pclk,
    input  logic              rst,
    input  logic              lcd_driver_en,
    input  logic              data_req,
    output logic [23:0]       pixel_data,
    output logic              almost_full,
    output logic              fb_rd_en,
    input  logic              fb_rd_gnt,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [15:0]       fb_rd_data,
    output logic              underflow,
    output logic              frame_done
);

    localparam int                FRAME    = H_ACT * V_ACT;
    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [RD_LAT-1:0] rd_vld;
    logic [CNT_W-1:0]  in_flight;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic [15:0]       fifo_data;
    logic [ADDR_W-1:0] pop_cnt;
    logic              flushing;
    logic              running;
    logic              issue;
    logic              push;
    logic              pop_req;
    logic              fifo_dry;
    logic              pop;
    logic              uf_now;
    logic              wrap;

    assign flushing = (state == ST_FLUSH);
    assign running  = (state == ST_RUN);

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + CNT_W'(rd_vld[i]);
        end
    end

    // Counting in-flight reads as occupied space is what keeps the FIFO from overflowing.
    assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
    assign fb_rd_en  = !flushing && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign issue     = fb_rd_en && fb_rd_gnt;
    assign push      = rd_vld[RD_LAT-1] && !flushing;

    assign pop_req   = running && data_req;
    assign fifo_dry  = (fifo_count == '0) && !push;
    assign pop       = pop_req && !fifo_dry;
    assign uf_now    = pop_req && fifo_dry;
    assign wrap      = pop_req && (pop_cnt == LAST_PIX);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FLUSH:   state_nxt = ST_PREFILL;
            ST_PREFILL: if (lcd_driver_en) state_nxt = ST_RUN;
            ST_RUN: begin
                if (!lcd_driver_en || (wrap && (underflow || uf_now))) begin
                    state_nxt = ST_FLUSH;
                end
            end
            default:    state_nxt = ST_FLUSH;
        endcase
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge lcd_pclk or posedge rst) begin
                if (rst) begin
                    rd_vld <= '0;
                end else begin
                    rd_vld <= flushing ? 1'b0 : issue;
                end
            end
        end else begin : g_latn
            always_ff @(posedge lcd_pclk or posedge rst) begin
                if (rst) begin
                    rd_vld <= '0;
                end else if (flushing) begin
                    rd_vld <= '0;
                end else begin
                    rd_vld <= {rd_vld[RD_LAT-2:0], issue};
                end
            end
        end
    endgenerate

    always_ff @(posedge lcd_pclk or posedge rst) begin
        if (rst) begin
            state       <= ST_FLUSH;
            fb_rd_addr  <= '0;
            pop_cnt     <= '0;
            underflow   <= 1'b0;
            frame_done  <= 1'b0;
            pixel_data  <= '0;
            almost_full <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_done  <= wrap;
            almost_full <= (fifo_count >= CNT_W'(AF_LEVEL));

            if (flushing) begin
                fb_rd_addr <= '0;
            end else if (issue) begin
                fb_rd_addr <= (fb_rd_addr == LAST_PIX) ? '0 : fb_rd_addr + 1'b1;
            end

            if (flushing) begin
                pop_cnt <= '0;
            end else if (pop_req) begin
                pop_cnt <= (pop_cnt == LAST_PIX) ? '0 : pop_cnt + 1'b1;
            end

            if (flushing) begin
                underflow <= 1'b0;
            end else if (uf_now) begin
                underflow <= 1'b1;
            end

            if (pop_req) begin
                pixel_data <= uf_now ? UF_COLOR : rgb565_to_888(fifo_data);
            end
        end
    end

    lcd_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (lcd_pclk),
        .rst       (rst),
        .flush     (flushing),
        .push      (push),
        .push_data (fb_rd_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_lcd_pixel_feeder.sv
// ============================================================================
//  Module   : tb_lcd_pixel_feeder
//  Brief    : Scoreboard bench for lcd_pixel_feeder on a reduced 8x4 frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lcd_pixel_feeder;

    localparam int          H      = 8;
    localparam int          V      = 4;
    localparam int          FRAME  = H * V;
    localparam int          LAT    = 3;
    localparam logic [23:0] UFC    = 24'hABCDEF;

    typedef struct {
        logic [23:0] pix;
        logic        fd;
        logic        uf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        data_req = 1'b0;
    logic        gnt = 1'b1;
    logic [23:0] pixel_data;
    logic        almost_full;
    logic        fb_rd_en;
    logic [18:0] fb_rd_addr;
    logic [15:0] fb_rd_data;
    logic        underflow;
    logic        frame_done;

    logic [15:0] lat_q [LAT];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_addr = 0;
    int          exp_pop = 0;
    int          n_issue = 0;
    bit          uf_model = 0;
    bit          req_exp = 0;
    bit          pend = 0;
    bit          mon_on = 0;
    logic [23:0] last_pix = '0;

    always #5 clk = ~clk;

    lcd_pixel_feeder #(
        .H_ACT(H), .V_ACT(V), .ADDR_W(19), .FIFO_DEPTH(16),
        .AF_LEVEL(12), .RD_LAT(LAT), .UF_COLOR(UFC)
    ) dut (
        .lcd_pclk(clk), .rst(rst), .lcd_driver_en(en), .data_req(data_req),
        .pixel_data(pixel_data), .almost_full(almost_full), .fb_rd_en(fb_rd_en),
        .fb_rd_gnt(gnt), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .underflow(underflow), .frame_done(frame_done)
    );

    function automatic logic [15:0] fbw(input int a);
        case (a)
            0:       return 16'hF800;
            1:       return 16'h07E0;
            2:       return 16'h001F;
            3:       return 16'h8410;
            default: return 16'((a * 2731 + 4660) & 16'hFFFF);
        endcase
    endfunction

    function automatic logic [23:0] conv(input logic [15:0] w);
        int r, g, b;
        r = (w >> 11) & 31;
        g = (w >> 5) & 63;
        b = w & 31;
        return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Framebuffer model with RD_LAT return delay
    always @(posedge clk) begin
        lat_q[0] <= (fb_rd_en && gnt) ? fbw(int'(fb_rd_addr)) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) lat_q[i] <= lat_q[i-1];
    end
    assign fb_rd_data = lat_q[LAT-1];

    // Read-address monitor
    always @(negedge clk) begin
        if (!rst && fb_rd_en && gnt) begin
            chk("rd_addr", 32'(fb_rd_addr), 32'(exp_addr));
            exp_addr = (exp_addr + 1) % FRAME;
            n_issue++;
        end
    end

    // Output monitor: compares the cycle after each accepted request
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got output with no expected entry");
            end else begin
                e = sb.pop_front();
                chk("pixel", 32'(pixel_data), 32'(e.pix));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("underflow", 32'(underflow), 32'(e.uf));
                last_pix = e.pix;
            end
        end else if (mon_on) begin
            chk("pixel_hold", 32'(pixel_data), 32'(last_pix));
            chk("frame_done_idle", 32'(frame_done), 32'd0);
        end
        pend = req_exp;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            data_req = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_pix(input logic [23:0] pix, input bit uf);
        exp_t e;
        uf_model = uf_model | uf;
        e.pix = pix;
        e.fd  = (exp_pop == FRAME - 1);
        e.uf  = uf_model;
        sb.push_back(e);
        exp_pop  = (exp_pop + 1) % FRAME;
        data_req = 1'b1;
        req_exp  = 1'b1;
        @(posedge clk);
        #1;
        data_req = 1'b0;
        req_exp  = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) pop_pix(conv(fbw(exp_pop)), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", 32'(pixel_data), 0);
        chk("rst_rd_en", 32'(fb_rd_en), 0);
        chk("rst_addr", 32'(fb_rd_addr), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_uf", 32'(underflow), 0);
        chk("rst_fd", 32'(frame_done), 0);
        rst = 1'b0;
        mon_on = 1;

        // Prefill with driver disabled
        idle(1);
        chk("first_rd_en", 32'(fb_rd_en), 1);
        chk("af_early", 32'(almost_full), 0);
        idle(24);
        chk("prefill_issues", 32'(n_issue), 16);
        chk("prefill_rd_en", 32'(fb_rd_en), 0);
        chk("prefill_af", 32'(almost_full), 1);
        chk("prefill_pixel", 32'(pixel_data), 0);

        // Enable and pop: colour conversion, full frame, wrap into next frame
        en = 1'b1;
        idle(1);
        pop_pix(24'hFF0000, 1'b0);
        pop_pix(24'h00FF00, 1'b0);
        pop_pix(24'h0000FF, 1'b0);
        pop_pix(24'h848284, 1'b0);
        pop_n(FRAME - 4);
        pop_n(10);

        // Starve the FIFO mid-line and run into the frame wrap
        idle(25);
        gnt = 1'b0;
        pop_n(16);
        for (int i = 0; i < 6; i++) pop_pix(UFC, 1'b1);
        idle(18);
        chk("uf_cleared", 32'(underflow), 0);
        exp_addr = 0;
        exp_pop  = 0;
        uf_model = 0;
        gnt = 1'b1;
        idle(25);
        pop_n(7);

        // Drop enable with reads in flight; the last request is still served
        en = 1'b0;
        pop_n(1);
        exp_addr = 0;
        exp_pop  = 0;
        idle(25);
        chk("reprefill_rd_en", 32'(fb_rd_en), 0);
        en = 1'b1;
        idle(1);
        pop_n(6);
        idle(2);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
